// File: rtl/mem_stage.sv
// mem_stage: MEM pipeline stage and MEM/WB register.
// Issues loads and stores to a variable-latency data memory over a req/ready
// handshake. Upstream stages are stalled while an access is outstanding, and
// the writeback payload is registered for the WB stage. An access that gets
// no memReady within TIMEOUT WAIT cycles is aborted with a busError pulse.
module mem_stage #(
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 255
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  inValid,
    input  logic                  inMemRead,
    input  logic                  inMemWrite,
    input  logic                  inWord,
    input  logic                  inRegWrite,
    input  logic [DATA_WIDTH-1:0] inAddr,
    input  logic [DATA_WIDTH-1:0] inStoreData,
    input  logic [4:0]            inRd,
    input  logic                  flush,
    output logic                  memReq,
    output logic                  memWe,
    output logic [DATA_WIDTH-1:0] memAddr,
    output logic [DATA_WIDTH-1:0] memWData,
    output logic [3:0]            memByteEn,
    input  logic                  memReady,
    input  logic [DATA_WIDTH-1:0] memRData,
    output logic                  stall,
    output logic                  wbValid,
    output logic                  wbRegWrite,
    output logic [4:0]            wbRd,
    output logic [DATA_WIDTH-1:0] wbData,
    output logic                  misaligned,
    output logic                  busError
);

    typedef enum logic [0:0] {
        StIdle,
        StWait
    } state_t;

    localparam logic [7:0] TIMER_MAX = 8'(TIMEOUT);

    state_t state;
    logic [7:0] timer;

    // Fields of the issued access, captured when leaving IDLE. Pure data:
    // they are only consumed while in WAIT, so they need no reset.
    logic [DATA_WIDTH-1:0] addr_p1;
    logic [DATA_WIDTH-1:0] wData_p1;
    logic [3:0]            byteEn_p1;
    logic                  we_p1;
    logic                  word_p1;
    logic [1:0]            lane_p1;
    logic [4:0]            rd_p1;
    logic                  loadRegWrite_p1;

    logic                  access;
    logic                  misalignedWord;
    logic                  issue;
    logic [3:0]            inByteEn;
    logic [DATA_WIDTH-1:0] inWData;
    logic                  timeoutHit;

    // Pick the addressed byte lane (little-endian) and sign-extend it.
    function automatic logic signed [DATA_WIDTH-1:0] signExtendByte(
        input logic [DATA_WIDTH-1:0] word,
        input logic [1:0]            lane
    );
        logic [7:0] b;
        case (lane)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        return {{(DATA_WIDTH-8){b[7]}}, b};
    endfunction

    assign access         = inValid & ~flush & (inMemRead | inMemWrite);
    assign misalignedWord = access & inWord & (inAddr[1:0] != 2'b00);
    assign issue          = access & ~misalignedWord;
    assign inByteEn       = inWord ? 4'b1111 : (4'b0001 << inAddr[1:0]);
    assign inWData        = inWord ? inStoreData : {4{inStoreData[7:0]}};
    assign timeoutHit     = (timer == TIMER_MAX);

    // Memory request and stall: driven straight from EX/MEM in IDLE so the
    // request leaves the same cycle, from the latched fields in WAIT. Reset
    // kills both immediately, even mid-access.
    always_comb begin
        memReq    = 1'b0;
        memWe     = 1'b0;
        memAddr   = '0;
        memWData  = '0;
        memByteEn = 4'b0000;
        stall     = 1'b0;
        if (!reset) begin
            if (state == StIdle) begin
                if (issue) begin
                    memReq    = 1'b1;
                    memWe     = inMemWrite;
                    memAddr   = {inAddr[DATA_WIDTH-1:2], 2'b00};
                    memWData  = inWData;
                    memByteEn = inByteEn;
                    stall     = 1'b1;
                end
            end else begin
                // A memReady arriving in the timeout cycle still wins.
                if (memReady || !timeoutHit) begin
                    memReq    = 1'b1;
                    memWe     = we_p1;
                    memAddr   = addr_p1;
                    memWData  = wData_p1;
                    memByteEn = byteEn_p1;
                end
                stall = ~memReady & ~timeoutHit;
            end
        end
    end

    // ---- stage boundary: EX/MEM -> outstanding access (p1) ----
    // Capture the access fields on the issuing edge.
    always_ff @(posedge clock) begin
        if (state == StIdle && issue) begin
            addr_p1         <= {inAddr[DATA_WIDTH-1:2], 2'b00};
            wData_p1        <= inWData;
            byteEn_p1       <= inByteEn;
            we_p1           <= inMemWrite;
            word_p1         <= inWord;
            lane_p1         <= inAddr[1:0];
            rd_p1           <= inRd;
            loadRegWrite_p1 <= inRegWrite & inMemRead;
        end
    end

    // ---- stage boundary: MEM -> MEM/WB ----
    // Access FSM, WAIT timer and the MEM/WB register; pulse outputs default low.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= StIdle;
            timer      <= 8'd0;
            wbValid    <= 1'b0;
            wbRegWrite <= 1'b0;
            wbRd       <= 5'd0;
            wbData     <= '0;
            misaligned <= 1'b0;
            busError   <= 1'b0;
        end else begin
            wbValid    <= 1'b0;
            wbRegWrite <= 1'b0;
            misaligned <= 1'b0;
            busError   <= 1'b0;
            case (state)
                StIdle: begin
                    if (!access) begin
                        // Non-memory op (or bubble): ALU result passes through.
                        wbValid    <= inValid & ~flush;
                        wbRegWrite <= inRegWrite & inValid & ~flush;
                        wbRd       <= inRd;
                        wbData     <= inAddr;
                    end else if (misalignedWord) begin
                        // Retire without touching memory and without a write.
                        misaligned <= 1'b1;
                        wbValid    <= 1'b1;
                        wbRd       <= inRd;
                        wbData     <= '0;
                    end else begin
                        // The cycle spent in WAIT is counted from 1.
                        state <= StWait;
                        timer <= 8'd1;
                    end
                end
                StWait: begin
                    if (memReady) begin
                        wbValid    <= 1'b1;
                        wbRegWrite <= loadRegWrite_p1;
                        wbRd       <= rd_p1;
                        if (we_p1) begin
                            wbData <= '0;
                        end else if (word_p1) begin
                            wbData <= memRData;
                        end else begin
                            wbData <= signExtendByte(memRData, lane_p1);
                        end
                        state <= StIdle;
                    end else if (timeoutHit) begin
                        busError <= 1'b1;
                        wbValid  <= 1'b1;
                        wbRd     <= rd_p1;
                        wbData   <= '0;
                        state    <= StIdle;
                    end else begin
                        timer <= timer + 8'd1;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Testbench for mem_stage: directed cases followed by a randomized
// instruction stream, each instruction checked against a transaction-level
// model of the MEM stage (request fields, stall, writeback, pulses).
module tb_mem_stage;

    localparam int TOUT = 4;

    logic        clock;
    logic        reset;
    logic        inValid, inMemRead, inMemWrite, inWord, inRegWrite;
    logic [31:0] inAddr, inStoreData;
    logic [4:0]  inRd;
    logic        flush;
    logic        memReq, memWe;
    logic [31:0] memAddr, memWData;
    logic [3:0]  memByteEn;
    logic        memReady;
    logic [31:0] memRData;
    logic        stall, wbValid, wbRegWrite;
    logic [4:0]  wbRd;
    logic [31:0] wbData;
    logic        misaligned, busError;

    int tests = 0;
    int fails = 0;

    mem_stage #(.DATA_WIDTH(32), .TIMEOUT(TOUT)) dut (
        .clock(clock), .reset(reset),
        .inValid(inValid), .inMemRead(inMemRead), .inMemWrite(inMemWrite),
        .inWord(inWord), .inRegWrite(inRegWrite), .inAddr(inAddr),
        .inStoreData(inStoreData), .inRd(inRd), .flush(flush),
        .memReq(memReq), .memWe(memWe), .memAddr(memAddr), .memWData(memWData),
        .memByteEn(memByteEn), .memReady(memReady), .memRData(memRData),
        .stall(stall), .wbValid(wbValid), .wbRegWrite(wbRegWrite), .wbRd(wbRd),
        .wbData(wbData), .misaligned(misaligned), .busError(busError)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
        tests++;
        assert (got === expv) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, got, expv);
        end
    endtask

    task automatic junkInputs();
        inValid     = 1'($urandom);
        inMemRead   = 1'($urandom);
        inMemWrite  = ~inMemRead;
        inWord      = 1'($urandom);
        inRegWrite  = 1'($urandom);
        inAddr      = $urandom;
        inStoreData = $urandom;
        inRd        = 5'($urandom);
        flush       = 1'($urandom);
    endtask

    // Present one instruction at posedge+1 and follow it to retirement.
    // lat = WAIT cycle in which memReady pulses; lat > TOUT means never.
    task automatic doInstr(input logic v, input logic mr, input logic mw, input logic wd,
                           input logic rw, input logic [31:0] a, input logic [31:0] sd,
                           input logic [4:0] rd, input logic fl, input int lat,
                           input logic [31:0] rdat);
        logic acc, mis;
        int lane, b;
        logic [3:0] be;
        logic [31:0] wdat, ld, aligned;
        inValid = v; inMemRead = mr; inMemWrite = mw; inWord = wd; inRegWrite = rw;
        inAddr = a; inStoreData = sd; inRd = rd; flush = fl; memReady = 1'b0;
        memRData = $urandom;
        #2;
        acc  = v & ~fl & (mr | mw);
        lane = int'(a[1:0]);
        mis  = acc & wd & (lane != 0);
        if (!acc || mis) begin
            chk("idle_memReq", memReq, 0);
            chk("idle_stall", stall, 0);
            @(posedge clock); #1;
            chk("misaligned", misaligned, mis);
            chk("busError_idle", busError, 0);
            chk("wbValid_idle", wbValid, acc ? 1'b1 : (v & ~fl));
            chk("wbRegWrite_idle", wbRegWrite, acc ? 1'b0 : (rw & v & ~fl));
            if (!acc) begin
                chk("wbRd_alu", wbRd, rd);
                chk("wbData_alu", wbData, a);
            end
            return;
        end
        be      = wd ? 4'hF : 4'(1 << lane);
        wdat    = wd ? sd : 32'(sd[7:0]) * 32'h01010101;
        aligned = a - 32'(lane);
        b = int'((rdat >> (8 * lane)) & 32'hFF);
        if (b > 127) b = b - 256;
        ld = wd ? rdat : 32'(b);
        chk("issue_memReq", memReq, 1);
        chk("issue_stall", stall, 1);
        chk("issue_memWe", memWe, mw);
        chk("issue_memAddr", memAddr, aligned);
        chk("issue_memByteEn", memByteEn, be);
        chk("issue_memWData", memWData, wdat);
        @(posedge clock); #1;
        chk("issue_wbValid", wbValid, 0);
        for (int w = 1; w <= TOUT; w++) begin
            junkInputs();
            if (w == lat) begin
                memReady = 1'b1;
                memRData = rdat;
            end else begin
                memRData = $urandom;
            end
            #2;
            if (w == lat || w < TOUT) begin
                chk("wait_memReq", memReq, 1);
                chk("wait_stall", stall, (w == lat) ? 1'b0 : 1'b1);
                chk("wait_memAddr", memAddr, aligned);
                chk("wait_memByteEn", memByteEn, be);
                chk("wait_memWe", memWe, mw);
                chk("wait_memWData", memWData, wdat);
            end else begin
                chk("tmo_memReq", memReq, 0);
                chk("tmo_stall", stall, 0);
            end
            @(posedge clock); #1;
            memReady = 1'b0;
            if (w == lat) begin
                chk("done_wbValid", wbValid, 1);
                chk("done_wbRegWrite", wbRegWrite, mr & rw);
                chk("done_wbRd", wbRd, rd);
                chk("done_wbData", wbData, mr ? ld : 32'h0);
                chk("done_busError", busError, 0);
                return;
            end else if (w == TOUT) begin
                chk("tmo_busError", busError, 1);
                chk("tmo_wbValid", wbValid, 1);
                chk("tmo_wbRegWrite", wbRegWrite, 0);
                return;
            end else begin
                chk("wait_wbValid", wbValid, 0);
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        inValid = 0; inMemRead = 0; inMemWrite = 0; inWord = 0; inRegWrite = 0;
        inAddr = 0; inStoreData = 0; inRd = 0; flush = 0; memReady = 0; memRData = 0;
        #2;
        chk("rst_memReq", memReq, 0);
        chk("rst_stall", stall, 0);
        chk("rst_wbValid", wbValid, 0);
        chk("rst_wbRegWrite", wbRegWrite, 0);
        chk("rst_wbRd", wbRd, 0);
        chk("rst_wbData", wbData, 0);
        chk("rst_memByteEn", memByteEn, 0);
        chk("rst_misaligned", misaligned, 0);
        chk("rst_busError", busError, 0);
        @(posedge clock); @(posedge clock); #1;
        reset = 1'b0;

        // ALU op passes through with one cycle of latency
        doInstr(1, 0, 0, 0, 1, 32'h1234, 0, 5'd5, 0, 0, 0);
        // word load, ready in third WAIT cycle
        doInstr(1, 1, 0, 1, 1, 32'h100, 0, 5'd7, 0, 3, 32'hDEADBEEF);
        // byte load from lane 3, negative byte
        doInstr(1, 1, 0, 0, 1, 32'h103, 0, 5'd8, 0, 1, 32'h80FF0011);
        // byte store replicated to all lanes
        doInstr(1, 0, 1, 0, 1, 32'h202, 32'h000000AB, 5'd9, 0, 2, 0);
        // misaligned word load, then an ALU op confirms the pulse was single
        doInstr(1, 1, 0, 1, 1, 32'h102, 0, 5'd3, 0, 1, 0);
        doInstr(1, 0, 0, 0, 1, 32'h55AA, 0, 5'd11, 0, 0, 0);
        // timeout, then ready in exactly the last allowed cycle
        doInstr(1, 1, 0, 1, 1, 32'h300, 0, 5'd4, 0, TOUT + 1, 0);
        doInstr(1, 0, 0, 0, 1, 32'h77, 0, 5'd12, 0, 0, 0);
        doInstr(1, 1, 0, 0, 1, 32'h301, 0, 5'd13, 0, TOUT, 32'h00007F00);
        // flushed load and invalid slot retire nothing
        doInstr(1, 1, 0, 1, 1, 32'h400, 0, 5'd14, 1, 1, 0);
        doInstr(0, 0, 0, 0, 1, 32'h404, 0, 5'd15, 0, 0, 0);
        // back-to-back loads
        doInstr(1, 1, 0, 1, 1, 32'h500, 0, 5'd16, 0, 1, 32'h12345678);
        doInstr(1, 1, 0, 0, 0, 32'h502, 0, 5'd17, 0, 1, 32'h00CD0000);

        // reset asserted mid-WAIT with the access still presented
        inValid = 1; inMemRead = 1; inMemWrite = 0; inWord = 1; inRegWrite = 1;
        inAddr = 32'h600; inRd = 5'd18; flush = 0;
        @(posedge clock); #2;
        chk("midrst_pre_memReq", memReq, 1);
        reset = 1'b1;
        #1;
        chk("midrst_memReq", memReq, 0);
        chk("midrst_stall", stall, 0);
        chk("midrst_memByteEn", memByteEn, 0);
        inValid = 0; inMemRead = 0;
        @(posedge clock); #1;
        reset = 1'b0;
        doInstr(1, 0, 0, 0, 1, 32'hCAFE, 0, 5'd19, 0, 0, 0);

        // randomized instruction stream
        for (int i = 0; i < 150; i++) begin
            logic v, mr, mw, wd, rw, fl;
            logic [31:0] a;
            int kind;
            v    = ($urandom_range(0, 7) != 0);
            kind = $urandom_range(0, 2);
            mr   = (kind == 1);
            mw   = (kind == 2);
            wd   = 1'($urandom);
            rw   = 1'($urandom);
            fl   = ($urandom_range(0, 7) == 0);
            a    = $urandom;
            if (wd && $urandom_range(0, 3) != 0) a[1:0] = 2'b00;
            doInstr(v, mr, mw, wd, rw, a, $urandom, 5'($urandom), fl,
                    $urandom_range(1, TOUT + 1), $urandom);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
